// File: rtl/ovld_reg_mc.sv
// rtl/ovld_reg_mc.sv - multi-channel output-valid register with snapshot stream (optional last_out via OVLD_REG_MC_LAST_EN)
module ovld_reg_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  input  logic [NUM_CH-1:0]            vld_in,
  input  logic                         ap_start,
  input  logic                         ap_done,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [CH_W-1:0]              ch_out,
  output logic                         vld_out,
  input  logic                         rdy_in,
  output logic                         busy,
  output logic                         overflow
`ifdef OVLD_REG_MC_LAST_EN
  ,
  output logic                         last_out
`endif
);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    prev_start_q, prev_start_d;
  logic                    prev_done_q, prev_done_d;
  logic [DATA_WIDTH-1:0]   data_reg_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   data_reg_d [NUM_CH];
  logic [NUM_CH-1:0]       ever_valid_q, ever_valid_d;
  logic [DATA_WIDTH-1:0]   snap_q [NUM_CH];
  logic [DATA_WIDTH-1:0]   snap_d [NUM_CH];
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [NUM_CH-1:0]       pending_left;
  logic [NUM_CH-1:0]       eff_mask;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic [CH_W-1:0]         ch_out_q, ch_out_d;
  logic                    overflow_q, overflow_d;
  logic                    rise_start, rise_done, accept;
`ifdef OVLD_REG_MC_LAST_EN
  logic                    last_q, last_d;
`endif

  // Edge detect and per-channel capture; data_reg_d doubles as the snapshot data
  always_comb begin
    prev_start_d = ap_start;
    prev_done_d  = ap_done;
    rise_start   = ap_start & ~prev_start_q;
    rise_done    = ap_done & ~prev_done_q;
    eff_mask     = '0;
    ever_valid_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      data_reg_d[c]   = vld_in[c] ? data_in[c*DATA_WIDTH +: DATA_WIDTH] : data_reg_q[c];
      eff_mask[c]     = vld_in[c] | (ever_valid_q[c] & ~rise_start);
      ever_valid_d[c] = (vld_in[c] | ever_valid_q[c]) & ~(rise_start & ~vld_in[c]);
    end
    accept = rise_done & (eff_mask != '0);
  end

  // Drain FSM: pending mask bookkeeping, snapshot load, overflow, registered stream outputs
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    overflow_d = overflow_q;
    pending_left = pending_q;
    if (state_q == S_DRAIN && rdy_in) begin
      pending_left = pending_q & (pending_q - NUM_CH'(1));
    end
    pending_d = pending_left;
    if (state_q == S_IDLE) begin
      if (accept) begin
        pending_d = eff_mask;
        snap_d    = data_reg_d;
        state_d   = S_DRAIN;
      end
    end else begin
      if (pending_left == '0) begin
        if (accept) begin
          pending_d = eff_mask;
          snap_d    = data_reg_d;
        end else begin
          state_d = S_IDLE;
        end
      end else if (accept) begin
        overflow_d = 1'b1;
      end
    end
    // present the lowest pending channel; outputs rest at zero when nothing is pending
    data_out_d = '0;
    ch_out_d   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        data_out_d = snap_d[i];
        ch_out_d   = CH_W'(i);
      end
    end
`ifdef OVLD_REG_MC_LAST_EN
    last_d = (pending_d != '0) && ((pending_d & (pending_d - NUM_CH'(1))) == '0);
`endif
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prev_start_q <= 1'b0;
      prev_done_q  <= 1'b0;
      ever_valid_q <= '0;
      pending_q    <= '0;
      data_out_q   <= '0;
      ch_out_q     <= '0;
      overflow_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_reg_q[c] <= '0;
        snap_q[c]     <= '0;
      end
`ifdef OVLD_REG_MC_LAST_EN
      last_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      prev_start_q <= prev_start_d;
      prev_done_q  <= prev_done_d;
      ever_valid_q <= ever_valid_d;
      pending_q    <= pending_d;
      data_out_q   <= data_out_d;
      ch_out_q     <= ch_out_d;
      overflow_q   <= overflow_d;
      data_reg_q   <= data_reg_d;
      snap_q       <= snap_d;
`ifdef OVLD_REG_MC_LAST_EN
      last_q       <= last_d;
`endif
    end
  end

  assign vld_out  = (state_q == S_DRAIN);
  assign busy     = (state_q == S_DRAIN);
  assign data_out = data_out_q;
  assign ch_out   = ch_out_q;
  assign overflow = overflow_q;
`ifdef OVLD_REG_MC_LAST_EN
  assign last_out = last_q;
`endif

endmodule
